// File: rtl/alu_exec.sv
// alu_exec: multi-cycle integer execute unit with valid/ready handshakes.
// Add, subtract, compare and logic ops finish in one cycle. Shifts run one
// bit per cycle through a working register, unless ALU_EXEC_FAST_SHIFT_EN
// is defined, in which case a barrel shifter gives single-cycle shifts and
// the SHIFT state and shift counter are not built.
module alu_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  // Single-cycle result for every opcode; unknown codes behave as ADD.
  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu_calc = a + b;
      OP_SLL:  alu_calc = a << sh;
      OP_SLT:  alu_calc = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_calc = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  alu_calc = a ^ b;
      OP_SRL:  alu_calc = a >> sh;
      OP_SRA:  alu_calc = $unsigned($signed(a) >>> sh);
      OP_OR:   alu_calc = a | b;
      OP_AND:  alu_calc = a & b;
      OP_SUB:  alu_calc = a - b;
      default: alu_calc = a + b;
    endcase
  endfunction

  state_t          state_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic [XLEN-1:0] calc_s;

  assign calc_s    = alu_calc(alu_op, op_a, op_b);
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign busy = 1'b0;

  // Control FSM: every op completes in IDLE and waits in DONE for retirement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid) begin
            result_r    <= calc_s;
            zero_r      <= (calc_s == {XLEN{1'b0}});
            state_r     <= DONE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
`else
  logic            busy_r;
  logic [SHW-1:0]  cnt_r;
  logic [XLEN-1:0] work_r;
  logic [3:0]      sop_r;
  logic [XLEN-1:0] step_s;
  logic            is_shift_s;

  assign busy       = busy_r;
  assign is_shift_s = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

  // One-bit shift of the working register in the latched direction.
  always_comb begin
    step_s = work_r;
    case (sop_r)
      OP_SLL:  step_s = {work_r[XLEN-2:0], 1'b0};
      OP_SRL:  step_s = {1'b0, work_r[XLEN-1:1]};
      OP_SRA:  step_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
      default: step_s = work_r;
    endcase
  end

  // Control FSM: IDLE accepts, SHIFT steps one bit per cycle, DONE holds the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b1;
      cnt_r       <= {SHW{1'b0}};
      work_r      <= {XLEN{1'b0}};
      sop_r       <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid) begin
            in_ready_r <= 1'b0;
            if (is_shift_s) begin
              sop_r  <= alu_op;
              work_r <= op_a;
              cnt_r  <= op_b[SHW-1:0];
              if (op_b[SHW-1:0] == {SHW{1'b0}}) begin
                result_r    <= op_a;
                zero_r      <= (op_a == {XLEN{1'b0}});
                state_r     <= DONE;
                out_valid_r <= 1'b1;
              end else begin
                state_r <= SHIFT;
                busy_r  <= 1'b1;
              end
            end else begin
              result_r    <= calc_s;
              zero_r      <= (calc_s == {XLEN{1'b0}});
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r - SHW'(1);
          if (cnt_r == SHW'(1)) begin
            result_r    <= step_s;
            zero_r      <= (step_s == {XLEN{1'b0}});
            state_r     <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec (XLEN=32). Expected results come from an
// independent behavioural model and are queued when a request is driven,
// then popped when the unit raises out_valid.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model written bit-by-bit rather than with operators on signed types.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r = a;
    case (op)
      4'd1: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      4'd5: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      4'd6: for (int i = 0; i < sh; i++) r = {a[31], r[31:1]};
      4'd2: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd3: r = {31'd0, (a < b)};
      4'd4: r = a ^ b;
      4'd7: r = a | b;
      4'd8: r = a & b;
      4'd9: r = a + ~b + 32'd1;
      default: r = a + b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, follow it to out_valid, compare, then retire it.
  // hold > 0 keeps out_ready low for that many cycles with a competing request.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] e;
    logic [32:0] got;
    int elat, ebusy, lat, bcnt, n, sh;
    bit is_sh;
    sh    = int'(b[4:0]);
    is_sh = (op == 4'd1) || (op == 4'd5) || (op == 4'd6);
    e     = model(op, a, b);
    exp_q.push_back({(e == 32'd0), e});
`ifdef ALU_EXEC_FAST_SHIFT_EN
    elat  = 1;
    ebusy = 0;
`else
    elat  = (is_sh && sh != 0) ? sh + 1 : 1;
    ebusy = (is_sh && sh != 0) ? sh : 0;
`endif
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_wait", 64'd0, 64'd1);
    in_valid  = 1'b1;
    alu_op    = op;
    op_a      = a;
    op_b      = b;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    got = exp_q.pop_front();
    check("latency", 64'(lat), 64'(elat));
    check("busy_cycles", 64'(bcnt), 64'(ebusy));
    check("result", 64'(result), 64'(got[31:0]));
    check("zero", 64'(zero), 64'(got[32]));
    check("ready_in_done", 64'(in_ready), 64'd0);
    check("busy_in_done", 64'(busy), 64'd0);
    if (hold > 0) begin
      in_valid = 1'b1;
      alu_op   = 4'd0;
      op_a     = 32'h1234;
      op_b     = 32'h1;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_result", 64'(result), 64'(got[31:0]));
        check("bp_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    check("retire_ready", 64'(in_ready), 64'd1);
    check("retire_valid", 64'(out_valid), 64'd0);
    if (hold > 0) begin
      tick();
      check("no_accept", 64'(out_valid), 64'd0);
      check("idle_ready", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    tick();
    check("release_ready", 64'(in_ready), 64'd1);

    do_op(4'd0,  32'h7FFF_FFFF, 32'h1, 0);
    do_op(4'd9,  32'd5, 32'd5, 0);
    do_op(4'd2,  32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'd3,  32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'd6,  32'h8000_0000, 32'd31, 0);
    do_op(4'd1,  32'h1, 32'h20, 0);
    do_op(4'd12, 32'd3, 32'd4, 0);
    do_op(4'd4,  32'hF0F0, 32'h0FF0, 10);
    do_op(4'd5,  32'hF000_000F, 32'd4, 0);
    do_op(4'd1,  32'h8000_0001, 32'd1, 0);
    do_op(4'd7,  32'h00FF_0000, 32'h0000_00FF, 0);
    do_op(4'd8,  32'hFF00_FF00, 32'h0F0F_0F0F, 0);
    for (int i = 0; i < 8; i++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 0);
    end

    // Reset during the fifth SHIFT cycle of an SLL by 20 discards the result.
    in_valid  = 1'b1;
    alu_op    = 4'd1;
    op_a      = 32'h0000_0003;
    op_b      = 32'd20;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_zero", 64'(zero), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 25; i++) begin
      tick();
      check("no_stale_valid", 64'(out_valid), 64'd0);
    end
    do_op(4'd0, 32'd40, 32'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
